arb_mux_nw: RTL and testbench
=============================

# arb_mux_nw

Parametrised N-channel, WIDTH-bit arbitrating multiplexer with a one-entry registered output stage, the successor to the fixed 4:1 16-bit combinational mux. It sits between several producers (ALU result, memory read port, immediate path, stack top) and a single consumer such as the stack write port. It arbitrates among valid requesters using fixed priority or round-robin, captures the winner's word, and presents it through a valid/ready handshake.

## Interface
- WIDTH, 16, data width per channel
- N, 4, number of input channels (2..16)
- SEL_W, 2, width of channel index; must equal ceil(log2(N))
- RR, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin

- CLK  input  1  clock, all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_data  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  input  N  channel k offers a word
- in_ready  output  N  one-hot or zero; channel k's word is taken this edge
- out_data  output  WIDTH  held word
- out_sel  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  out_data/out_sel hold a word
- out_ready  input  1  consumer takes the word this edge

## Operation
- State: output register (out_data, out_sel, out_valid) and round-robin pointer ptr[SEL_W-1:0].
- accept = !out_valid || out_ready. This is combinational and allows full throughput.
- Grant g is combinational, computed among channels with in_valid=1:
  - RR=0: the lowest index.
  - RR=1: the first valid index searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap modulo N).
- in_ready[g]=1 only when accept=1 and at least one in_valid is set. All other in_ready bits are 0.
- in_ready must not depend on in_data. It may depend on in_valid.
- Transfer on edge (accept && |in_valid):
  - out_data <= in_data[g].
  - out_sel <= g.
  - out_valid <= 1.
  - RR=1: ptr <= (g==N-1) ? 0 : g+1.
- Drain without refill (out_valid && out_ready && !|in_valid): out_valid <= 0. out_data and out_sel keep their last values.
- Stall (out_valid && !out_ready): out_data, out_sel, out_valid and ptr hold. All in_ready are 0.
- No valid requesters: ptr unchanged and no grant.
- RR=0: ptr is unused and stays 0.
- Producers must hold in_data/in_valid until they see in_ready. The block never drops or duplicates a word.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_sel=0, ptr=0.
  - in_ready=0 while reset is asserted.
- Latency: a word accepted at edge t is visible on out_data with out_valid=1 after edge t.
- Throughput: one word per cycle while out_ready=1 is held.
- Simultaneous drain and load in the same cycle: the new word replaces the old one and out_valid stays 1.
- Reset asserted mid-transfer: the held word is discarded and ptr returns to 0 at once. A producer handshake in the same cycle does not complete.
- Single requester: that requester is granted every cycle regardless of ptr.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0,… and no channel waits more than N-1 transfers.

## Test plan
- Reset then idle: with reset=1 for 3 cycles, outputs read out_valid=0, out_data=0, out_sel=0, in_ready=0. After release with in_valid=0, they stay unchanged.
- Single channel: N=4, in_data ch2=16'h00A5, in_valid=4'b0100, out_ready=1. Expect in_ready=4'b0100, then out_data=16'h00A5, out_sel=2, out_valid=1 one cycle later.
- Round-robin: RR=1, in_valid=4'b1111 with distinct data 16'h1111..16'h4444 held, out_ready=1 for 8 cycles. Expect out_sel sequence 0,1,2,3,0,1,2,3 and matching data.
- Fixed priority: RR=0, in_valid=4'b1010 held. Expect out_sel=1 every cycle and in_ready[3]=0 throughout.
- Backpressure: load 16'hBEEF from ch0, then drop out_ready=0 for 5 cycles with ch1 valid. Expect out_data=16'hBEEF held and in_ready=0. After raising out_ready, ch1's word appears on the next cycle.
- Reset mid-stream: during the round-robin sequence with out_sel=2 held, assert reset. Expect out_valid=0 immediately. After release, the first grant goes to ch0 (ptr=0).

Source files
------------

// File: rtl/arb_mux_nw_if.sv
// Handshake bundle for arb_mux_nw: N producer channels in, one registered consumer channel out.
interface arb_mux_nw_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/arb_mux_nw.sv
// N-channel arbitrating mux (fixed priority or round-robin) feeding a one-entry
// registered output stage with valid/ready handshake.
module arb_mux_nw #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2,
    parameter int unsigned RR    = 1
) (
    input logic          CLK,
    input logic          reset,
    arb_mux_nw_if.slave  bus
);
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] sel_q;
    logic             valid_q;
    logic [SEL_W-1:0] ptr_q;

    logic             accept;
    logic             any_valid;
    logic             take;
    logic             found;
    logic [SEL_W-1:0] gnt;
    logic [SEL_W-1:0] idx;
    logic [WIDTH-1:0] win_data;
    logic [N-1:0]     rdy;

    assign accept    = !valid_q || bus.out_ready;
    assign any_valid = |bus.in_valid;
    // Reset gates the handshake so no producer transfer completes while it is held.
    assign take      = accept && any_valid && !reset;

    // Search order starts at ptr in round-robin mode, at 0 in fixed-priority mode.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (RR != 0) idx = SEL_W'((int'(ptr_q) + i) % int'(N));
            else         idx = SEL_W'(i);
            if (!found && bus.in_valid[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    always_comb begin
        win_data = '0;
        rdy      = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (gnt == SEL_W'(k)) win_data = bus.in_data[k*WIDTH +: WIDTH];
            rdy[k] = take && (gnt == SEL_W'(k));
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else if (take) begin
            data_q  <= win_data;
            sel_q   <= gnt;
            valid_q <= 1'b1;
            if (RR != 0) ptr_q <= (gnt == SEL_W'(N - 1)) ? '0 : gnt + 1'b1;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_arb_mux_nw.sv
// Directed, table-driven bench for arb_mux_nw: round-robin instance driven from a vector
// table, fixed-priority instance checked by a short hand-written sequence.
module tb_arb_mux_nw;
    localparam logic [63:0] DALL = 64'h4444_3333_2222_1111;
    localparam logic [63:0] DA5  = 64'h0000_00A5_0000_0000;
    localparam logic [63:0] DBF  = 64'h4444_3333_2222_BEEF;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic        ordy;
        logic [63:0] data;
        logic [3:0]  rdy;
        logic        ov;
        logic [15:0] od;
        logic [1:0]  os;
    } vec_t;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_data = '0;
    logic [3:0]  in_valid = '0;
    logic        out_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];

    always #5 CLK = ~CLK;

    arb_mux_nw_if #(.WIDTH(16), .N(4), .SEL_W(2)) rr_if ();
    arb_mux_nw_if #(.WIDTH(16), .N(4), .SEL_W(2)) fp_if ();

    assign rr_if.in_data   = in_data;
    assign rr_if.in_valid  = in_valid;
    assign rr_if.out_ready = out_ready;
    assign fp_if.in_data   = in_data;
    assign fp_if.in_valid  = in_valid;
    assign fp_if.out_ready = out_ready;

    arb_mux_nw #(.WIDTH(16), .N(4), .SEL_W(2), .RR(1)) dut_rr (
        .CLK   (CLK),
        .reset (reset),
        .bus   (rr_if.slave)
    );

    arb_mux_nw #(.WIDTH(16), .N(4), .SEL_W(2), .RR(0)) dut_fp (
        .CLK   (CLK),
        .reset (reset),
        .bus   (fp_if.slave)
    );

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic o, input logic [63:0] d,
                       input logic [3:0] rdy, input logic ov, input logic [15:0] od,
                       input logic [1:0] os);
        vecs.push_back('{rst: r, valid: v, ordy: o, data: d, rdy: rdy, ov: ov, od: od, os: os});
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic o, input logic [63:0] d);
        @(negedge CLK);
        reset     = r;
        in_valid  = v;
        out_ready = o;
        in_data   = d;
        #1;
    endtask

    initial begin
        // Reset then idle
        for (int k = 0; k < 3; k++) add(1'b1, 4'b0000, 1'b0, DALL, 4'b0000, 1'b0, 16'h0, 2'd0);
        for (int k = 0; k < 2; k++) add(1'b0, 4'b0000, 1'b1, DALL, 4'b0000, 1'b0, 16'h0, 2'd0);
        // Single channel, then drain without refill
        add(1'b0, 4'b0100, 1'b1, DA5, 4'b0100, 1'b1, 16'h00A5, 2'd2);
        add(1'b0, 4'b0000, 1'b1, DA5, 4'b0000, 1'b0, 16'h00A5, 2'd2);
        add(1'b1, 4'b0000, 1'b1, DALL, 4'b0000, 1'b0, 16'h0, 2'd0);
        // Round-robin with all channels valid, then reset with out_sel=2 held
        for (int k = 0; k < 11; k++)
            add(1'b0, 4'b1111, 1'b1, DALL, 4'(1 << (k % 4)), 1'b1, 16'(16'h1111 * (k % 4 + 1)),
                2'(k % 4));
        add(1'b1, 4'b1111, 1'b1, DALL, 4'b0000, 1'b0, 16'h0, 2'd0);
        add(1'b0, 4'b1111, 1'b1, DALL, 4'b0001, 1'b1, 16'h1111, 2'd0);
        // Backpressure: BEEF held for 5 stalled cycles, then ch1 goes through
        add(1'b0, 4'b0001, 1'b1, DBF, 4'b0001, 1'b1, 16'hBEEF, 2'd0);
        for (int k = 0; k < 5; k++) add(1'b0, 4'b0010, 1'b0, DBF, 4'b0000, 1'b1, 16'hBEEF, 2'd0);
        add(1'b0, 4'b0010, 1'b1, DBF, 4'b0010, 1'b1, 16'h2222, 2'd1);
        add(1'b0, 4'b0000, 1'b1, DBF, 4'b0000, 1'b0, 16'h2222, 2'd1);
        // Pointer continuity after stall and idle
        add(1'b0, 4'b1111, 1'b1, DALL, 4'b0100, 1'b1, 16'h3333, 2'd2);
        add(1'b0, 4'b1010, 1'b1, DALL, 4'b1000, 1'b1, 16'h4444, 2'd3);
        add(1'b0, 4'b1010, 1'b1, DALL, 4'b0010, 1'b1, 16'h2222, 2'd1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].ordy, vecs[i].data);
            check("rr_in_ready", i, 32'(rr_if.in_ready), 32'(vecs[i].rdy));
            if (vecs[i].rst) check("rr_reset_immediate_valid", i, 32'(rr_if.out_valid), 32'd0);
            @(posedge CLK);
            #1;
            check("rr_out_valid", i, 32'(rr_if.out_valid), 32'(vecs[i].ov));
            check("rr_out_data", i, 32'(rr_if.out_data), 32'(vecs[i].od));
            check("rr_out_sel", i, 32'(rr_if.out_sel), 32'(vecs[i].os));
        end

        // Fixed priority: ch1 always beats ch3
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 4'b1010, 1'b1, DALL);
            check("fp_in_ready", k, 32'(fp_if.in_ready), 32'h2);
            check("fp_in_ready3_low", k, 32'(fp_if.in_ready[3]), 32'd0);
            @(posedge CLK);
            #1;
            check("fp_out_sel", k, 32'(fp_if.out_sel), 32'd1);
            check("fp_out_data", k, 32'(fp_if.out_data), 32'h2222);
            check("fp_out_valid", k, 32'(fp_if.out_valid), 32'd1);
        end
        drive(1'b0, 4'b1010, 1'b0, DALL);
        check("fp_stall_in_ready", 0, 32'(fp_if.in_ready), 32'h0);
        @(posedge CLK);
        #1;
        check("fp_stall_sel", 0, 32'(fp_if.out_sel), 32'd1);
        check("fp_stall_valid", 0, 32'(fp_if.out_valid), 32'd1);
        drive(1'b0, 4'b1000, 1'b1, DALL);
        check("fp_single_in_ready", 0, 32'(fp_if.in_ready), 32'h8);
        @(posedge CLK);
        #1;
        check("fp_single_data", 0, 32'(fp_if.out_data), 32'h4444);
        check("fp_single_sel", 0, 32'(fp_if.out_sel), 32'd3);
        drive(1'b0, 4'b0011, 1'b1, DALL);
        check("fp_lowest_in_ready", 0, 32'(fp_if.in_ready), 32'h1);
        @(posedge CLK);
        #1;
        check("fp_lowest_sel", 0, 32'(fp_if.out_sel), 32'd0);
        check("fp_lowest_data", 0, 32'(fp_if.out_data), 32'h1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
